// File: rtl/pulse_train_gen.sv
// Pulse train generator: turns a single-cycle start request into N pulses on sig_out
// with programmable active and gap widths, reporting busy/done for handshaking.
module pulse_train_gen #(
  parameter int   W        = 16,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] hi_cnt,
  input  logic [W-1:0] lo_cnt,
  input  logic [7:0]   num_pulses,
  output logic         sig_out,
  output logic         busy,
  output logic         done
);

  // state  | meaning
  // IDLE   | waiting for start, sig_out at idle level
  // HIGH   | active phase of a pulse, phase counter running
  // LOW    | gap between pulses, phase counter running
  // DONE   | train finished normally, done asserted for this one cycle
  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_DONE} state_t;

  state_t       state;
  logic [W-1:0] phase_cnt;
  logic [W-1:0] hi_r;
  logic [W-1:0] lo_r;
  logic [7:0]   pulses_left;
  logic [W-1:0] hi_eff;
  logic [W-1:0] lo_eff;

  // Zero widths are promoted to one cycle so every phase is visible.
  assign hi_eff = (hi_cnt == '0) ? W'(1) : hi_cnt;
  assign lo_eff = (lo_cnt == '0) ? W'(1) : lo_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      sig_out     <= IDLE_LVL;
      busy        <= 1'b0;
      done        <= 1'b0;
      phase_cnt   <= '0;
      hi_r        <= '0;
      lo_r        <= '0;
      pulses_left <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            hi_r        <= hi_eff;
            lo_r        <= lo_eff;
            pulses_left <= num_pulses;
            if (num_pulses != 8'd0) begin
              state     <= S_HIGH;
              sig_out   <= ~IDLE_LVL;
              busy      <= 1'b1;
              phase_cnt <= hi_eff;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end

        S_HIGH: begin
          if (abort) begin
            state       <= S_IDLE;
            sig_out     <= IDLE_LVL;
            busy        <= 1'b0;
            phase_cnt   <= '0;
            pulses_left <= '0;
          end else if (phase_cnt == W'(1)) begin
            sig_out <= IDLE_LVL;
            if (pulses_left == 8'd1) begin
              // Final pulse ends straight into DONE, no trailing gap.
              state       <= S_DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              phase_cnt   <= '0;
              pulses_left <= '0;
            end else begin
              state       <= S_LOW;
              phase_cnt   <= lo_r;
              pulses_left <= pulses_left - 8'd1;
            end
          end else begin
            phase_cnt <= phase_cnt - W'(1);
          end
        end

        S_LOW: begin
          if (abort) begin
            state       <= S_IDLE;
            sig_out     <= IDLE_LVL;
            busy        <= 1'b0;
            phase_cnt   <= '0;
            pulses_left <= '0;
          end else if (phase_cnt == W'(1)) begin
            state     <= S_HIGH;
            sig_out   <= ~IDLE_LVL;
            phase_cnt <= hi_r;
          end else begin
            phase_cnt <= phase_cnt - W'(1);
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end

        default: begin
          state   <= S_IDLE;
          sig_out <= IDLE_LVL;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen: a reference model pushes expected
// {sig_out,busy,done} per cycle into a queue, popped and compared every cycle.
module tb_pulse_train_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] hi_cnt;
  logic [15:0] lo_cnt;
  logic [7:0]  num_pulses;
  logic        sig_a, busy_a, done_a;
  logic        sig_b, busy_b, done_b;

  int vectors = 0;
  int errors  = 0;
  logic [2:0] exp_q[$];
  logic [2:0] e;

  always #5 clk = ~clk;

  pulse_train_gen #(.W(16), .IDLE_LVL(1'b0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .hi_cnt(hi_cnt), .lo_cnt(lo_cnt), .num_pulses(num_pulses),
    .sig_out(sig_a), .busy(busy_a), .done(done_a)
  );

  pulse_train_gen #(.W(16), .IDLE_LVL(1'b1)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .hi_cnt(hi_cnt), .lo_cnt(lo_cnt), .num_pulses(num_pulses),
    .sig_out(sig_b), .busy(busy_b), .done(done_b)
  );

  // Expected per-cycle {sig_out,busy,done} starting the cycle after the accepting edge,
  // ending with the done cycle and one trailing idle cycle.
  function automatic void push_train(int hi, int lo, int n, logic idle);
    int h = (hi == 0) ? 1 : hi;
    int l = (lo == 0) ? 1 : lo;
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < h; i++) exp_q.push_back({~idle, 1'b1, 1'b0});
      if (p < n - 1)
        for (int i = 0; i < l; i++) exp_q.push_back({idle, 1'b1, 1'b0});
    end
    exp_q.push_back({idle, 1'b0, 1'b1});
    exp_q.push_back({idle, 1'b0, 1'b0});
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      abort = 1'($urandom_range(0, 1));
      hi_cnt = 16'($urandom);
      num_pulses = 8'($urandom);
      exp_q.push_back(3'b000);
      e = exp_q.pop_front();
      vectors++;
      if ({sig_a, busy_a, done_a} !== e) begin
        errors++;
        $display("FAIL reset cyc %0d: got %b expected %b", k, {sig_a, busy_a, done_a}, e);
      end
      vectors++;
      if ({sig_b, busy_b, done_b} !== 3'b100) begin
        errors++;
        $display("FAIL reset_idle1 cyc %0d: got %b expected 100", k, {sig_b, busy_b, done_b});
      end
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_basic_train();
    @(negedge clk);
    hi_cnt = 16'd3; lo_cnt = 16'd2; num_pulses = 8'd2; start = 1'b1;
    push_train(3, 2, 2, 1'b0);
    for (int k = 1; exp_q.size() > 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      e = exp_q.pop_front();
      vectors++;
      if ({sig_a, busy_a, done_a} !== e) begin
        errors++;
        $display("FAIL basic_train cyc %0d: got %b expected %b", k, {sig_a, busy_a, done_a}, e);
      end
    end
  endtask

  task automatic test_zero_pulses();
    @(negedge clk);
    hi_cnt = 16'd4; lo_cnt = 16'd4; num_pulses = 8'd0; start = 1'b1;
    push_train(4, 4, 0, 1'b0);
    exp_q.push_back(3'b000);
    for (int k = 1; exp_q.size() > 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      e = exp_q.pop_front();
      vectors++;
      if ({sig_a, busy_a, done_a} !== e) begin
        errors++;
        $display("FAIL zero_pulses cyc %0d: got %b expected %b", k, {sig_a, busy_a, done_a}, e);
      end
    end
  endtask

  task automatic test_zero_widths();
    @(negedge clk);
    hi_cnt = 16'd0; lo_cnt = 16'd0; num_pulses = 8'd3; start = 1'b1;
    push_train(0, 0, 3, 1'b0);
    for (int k = 1; exp_q.size() > 0; k++) begin
      @(negedge clk);
      start = (k == 2);
      e = exp_q.pop_front();
      vectors++;
      if ({sig_a, busy_a, done_a} !== e) begin
        errors++;
        $display("FAIL zero_widths cyc %0d: got %b expected %b", k, {sig_a, busy_a, done_a}, e);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_abort();
    @(negedge clk);
    hi_cnt = 16'd5; lo_cnt = 16'd5; num_pulses = 8'd4; start = 1'b1;
    push_train(5, 5, 4, 1'b0);
    while (exp_q.size() > 17) void'(exp_q.pop_back());
    repeat (6) exp_q.push_back(3'b000);
    for (int k = 1; exp_q.size() > 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      e = exp_q.pop_front();
      vectors++;
      if ({sig_a, busy_a, done_a} !== e) begin
        errors++;
        $display("FAIL abort_gap cyc %0d: got %b expected %b", k, {sig_a, busy_a, done_a}, e);
      end
      abort = (k == 17);
    end
    abort = 1'b0;
  endtask

  task automatic test_reset_mid_train();
    @(negedge clk);
    hi_cnt = 16'd5; lo_cnt = 16'd5; num_pulses = 8'd4; start = 1'b1;
    push_train(5, 5, 4, 1'b0);
    while (exp_q.size() > 3) void'(exp_q.pop_back());
    repeat (6) exp_q.push_back(3'b000);
    for (int k = 1; exp_q.size() > 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      e = exp_q.pop_front();
      vectors++;
      if ({sig_a, busy_a, done_a} !== e) begin
        errors++;
        $display("FAIL reset_mid cyc %0d: got %b expected %b", k, {sig_a, busy_a, done_a}, e);
      end
      rst = (k == 3);
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    hi_cnt = 16'd1; lo_cnt = 16'd1; num_pulses = 8'd1; start = 1'b1;
    repeat (2) begin
      exp_q.push_back(3'b110);
      exp_q.push_back(3'b001);
      exp_q.push_back(3'b000);
    end
    repeat (2) exp_q.push_back(3'b000);
    for (int k = 1; exp_q.size() > 0; k++) begin
      @(negedge clk);
      start = (k <= 5);
      e = exp_q.pop_front();
      vectors++;
      if ({sig_a, busy_a, done_a} !== e) begin
        errors++;
        $display("FAIL back_to_back cyc %0d: got %b expected %b", k, {sig_a, busy_a, done_a}, e);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_idle_high_capture();
    @(negedge clk);
    hi_cnt = 16'd2; lo_cnt = 16'd1; num_pulses = 8'd1; start = 1'b1;
    push_train(2, 1, 1, 1'b1);
    for (int k = 1; exp_q.size() > 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      hi_cnt = 16'd9;
      e = exp_q.pop_front();
      vectors++;
      if ({sig_b, busy_b, done_b} !== e) begin
        errors++;
        $display("FAIL idle_high_capture cyc %0d: got %b expected %b", k, {sig_b, busy_b, done_b}, e);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    hi_cnt = '0; lo_cnt = '0; num_pulses = '0;
    test_reset();
    test_basic_train();
    test_zero_pulses();
    test_zero_widths();
    test_abort();
    test_reset_mid_train();
    test_back_to_back();
    test_idle_high_capture();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
